// File: rtl/alu_checker_if.sv
// alu_checker_if: stimulus-plus-response beat channel between an ALU harness and alu_checker.
interface alu_checker_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUop;
  logic [31:0] Result;
  logic        Overflow;
  logic        CarryOut;
  logic        Zero;
  modport master (output in_valid, A, B, ALUop, Result, Overflow, CarryOut, Zero, input in_ready);
  modport slave  (input in_valid, A, B, ALUop, Result, Overflow, CarryOut, Zero, output in_ready);
endinterface

// File: rtl/alu_checker.sv
// alu_checker: 3-stage pipelined scoreboard comparing ALU responses against a reference model.
// Define ALU_CHK_STOP_ON_FAIL_EN to stop accepting beats after the first failure until clr.
module alu_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  alu_checker_if.slave     s,
  output logic             mismatch,
  output logic [4:0]       mismatch_mask,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state, state_n;
  logic acc, v1, v2, legal, arith, eo, ec, fail3, pass3;
  logic [31:0] a1, b1, r1, er;
  logic [2:0] op1;
  logic o1, c1, z1;
  logic [32:0] sum, dif;
  logic [4:0] m, m2;
  logic [CNT_W-1:0] idx;
  assign acc = s.in_valid && s.in_ready;
  assign fail3 = v2 && m2 != 5'd0;
  assign pass3 = v2 && m2 == 5'd0;
`ifdef ALU_CHK_STOP_ON_FAIL_EN
  assign s.in_ready = state != HALT;
`else
  assign s.in_ready = 1'b1;
`endif
  always_comb begin
    sum = {1'b0, a1} + {1'b0, b1};
    dif = {1'b0, a1} - {1'b0, b1};
    legal = op1 == 3'b000 || op1 == 3'b001 || op1 == 3'b010 || op1 == 3'b110 || op1 == 3'b111;
    arith = op1 == 3'b010 || op1 == 3'b110;
    er = op1 == 3'b000 ? a1 & b1 :
         op1 == 3'b001 ? a1 | b1 :
         op1 == 3'b010 ? sum[31:0] :
         op1 == 3'b110 ? dif[31:0] :
         {31'd0, $signed(a1) < $signed(b1)};
    eo = op1 == 3'b010 ? (a1[31] == b1[31] && sum[31] != a1[31]) : (a1[31] != b1[31] && dif[31] != a1[31]);
    ec = op1 == 3'b010 ? sum[32] : dif[32];
    m = legal ? {1'b0, r1 != er, arith && o1 != eo, arith && c1 != ec, z1 != (er == 32'd0)} : 5'b10000;
  end
  always_comb begin
    state_n = clr ? IDLE : (state == IDLE && acc) ? RUN : state;
`ifdef ALU_CHK_STOP_ON_FAIL_EN
    if (!clr && state == RUN && fail3) state_n = HALT;
`endif
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (acc) begin
      a1 <= s.A;
      b1 <= s.B;
      r1 <= s.Result;
      op1 <= s.ALUop;
      o1 <= s.Overflow;
      c1 <= s.CarryOut;
      z1 <= s.Zero;
    end
    m2 <= m;
    if (rst || clr) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      mismatch <= 1'b0;
      mismatch_mask <= 5'd0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      first_fail_idx <= '0;
      err <= 1'b0;
      idx <= '0;
    end else begin
      v1 <= acc;
      v2 <= v1;
      mismatch <= fail3;
      if (v2 && idx != MAX) idx <= idx + 1'b1;
      if (pass3 && pass_cnt != MAX) pass_cnt <= pass_cnt + 1'b1;
      if (fail3) begin
        mismatch_mask <= m2;
        if (fail_cnt != MAX) fail_cnt <= fail_cnt + 1'b1;
        if (!err) begin
          err <= 1'b1;
          first_fail_idx <= idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_checker.sv
// tb_alu_checker: directed vector table plus hand-written pipeline, clear and reset sequences.
module tb_alu_checker;
  localparam int W = 4;
  localparam int SATN = (1 << W) + 3;
  localparam logic [W-1:0] MAXC = '1;
`ifdef ALU_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, clr, mismatch, err;
  logic [4:0] mmask;
  logic [W-1:0] pc, fc, ffi;
  always #5 clk = ~clk;
  alu_checker_if bus ();
  alu_checker #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .s(bus),
    .mismatch(mismatch), .mismatch_mask(mmask), .pass_cnt(pc), .fail_cnt(fc),
    .first_fail_idx(ffi), .err(err)
  );
  typedef struct packed {
    logic [2:0] op;
    logic [31:0] a, b, r;
    logic o, c, z;
    logic [4:0] m;
  } vec_t;
  vec_t v [11];
  int checks = 0, errors = 0;
  logic [W-1:0] pc_m, fc_m, ffi_m, idx_m;
  logic [4:0] mask_m;
  logic err_m;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    bus.in_valid = 1'b1;
    bus.ALUop = x.op;
    bus.A = x.a;
    bus.B = x.b;
    bus.Result = x.r;
    bus.Overflow = x.o;
    bus.CarryOut = x.c;
    bus.Zero = x.z;
  endtask
  task automatic model_clear();
    pc_m = '0; fc_m = '0; ffi_m = '0; idx_m = '0; mask_m = '0; err_m = 1'b0;
  endtask
  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask
  task automatic chk_outs(input string n);
    chk({n, ".pass_cnt"}, pc, pc_m);
    chk({n, ".fail_cnt"}, fc, fc_m);
    chk({n, ".err"}, err, err_m);
    chk({n, ".first_fail_idx"}, ffi, ffi_m);
    chk({n, ".mask"}, mmask, mask_m);
  endtask
  initial begin
    v[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 5'b00000};
    v[1]  = '{3'b110, 32'h80000001, 32'h7FFFFFF2, 32'h0000000F, 1'b0, 1'b0, 1'b0, 5'b00100};
    v[2]  = '{3'b111, 32'h80000001, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 1'b0, 5'b00000};
    v[3]  = '{3'b100, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 5'b10000};
    v[4]  = '{3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0, 5'b00001};
    v[5]  = '{3'b000, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b1, 1'b1, 5'b00000};
    v[6]  = '{3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b1, 1'b0, 5'b00000};
    v[7]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 5'b00010};
    v[8]  = '{3'b110, 32'h00000001, 32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 5'b01000};
    v[9]  = '{3'b111, 32'h00000001, 32'h80000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 5'b01001};
    v[10] = '{3'b011, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0, 5'b10000};
    rst = 1'b1; clr = 1'b0; bus.in_valid = 1'b0;
    drive(v[0]);
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    model_clear();
    chk_outs("reset");
    chk("reset.mismatch", mismatch, 0);
    chk("reset.in_ready", bus.in_ready, 1);
    for (int i = 0; i < 11; i++) begin
      drive(v[i]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d.lat0", i), mismatch, 0);
      @(negedge clk);
      chk($sformatf("v%0d.lat1", i), mismatch, 0);
      @(negedge clk);
      chk($sformatf("v%0d.mismatch", i), mismatch, v[i].m != 5'd0);
      if (v[i].m == 5'd0) begin
        if (pc_m != MAXC) pc_m++;
      end else begin
        if (fc_m != MAXC) fc_m++;
        mask_m = v[i].m;
        if (!err_m) begin err_m = 1'b1; ffi_m = idx_m; end
      end
      if (idx_m != MAXC) idx_m++;
      chk_outs($sformatf("v%0d", i));
      @(negedge clk);
      chk($sformatf("v%0d.pulse", i), mismatch, 0);
      chk($sformatf("v%0d.in_ready", i), bus.in_ready, (STOP && v[i].m != 5'd0) ? 0 : 1);
      if (STOP && v[i].m != 5'd0) do_clr();
    end
    do_clr();
    drive(v[1]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sub_ovf.early", mismatch, 0);
    @(negedge clk);
    chk("sub_ovf.mismatch", mismatch, 1);
    pc_m = '0; fc_m = 1; err_m = 1'b1; ffi_m = '0; mask_m = 5'b00100;
    chk_outs("sub_ovf");
    do_clr();
    chk_outs("after_clr");
    chk("after_clr.in_ready", bus.in_ready, 1);
    drive(v[2]);
    @(negedge clk);
    drive(v[3]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("slt_ill.first_pass", mismatch, 0);
    @(negedge clk);
    chk("slt_ill.mismatch", mismatch, 1);
    pc_m = 1; fc_m = 1; err_m = 1'b1; ffi_m = 1; mask_m = 5'b10000;
    chk_outs("slt_ill");
    do_clr();
    for (int k = 0; k < SATN; k++) begin
      vec_t x;
      x.op = 3'b000;
      x.a = $urandom;
      x.b = $urandom;
      x.r = x.a & x.b;
      x.z = x.r == 32'd0;
      x.o = 1'($urandom_range(1));
      x.c = 1'($urandom_range(1));
      x.m = 5'd0;
      drive(x);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    pc_m = MAXC;
    chk_outs("saturate");
    do_clr();
    drive(v[3]);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_beat.mismatch", mismatch, 0);
    chk_outs("clr_beat");
    drive(v[3]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    do_clr();
    repeat (2) @(negedge clk);
    chk("clr_flight.mismatch", mismatch, 0);
    chk_outs("clr_flight");
    drive(v[0]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    pc_m = 1;
    chk_outs("pre_rst");
    drive(v[3]);
    @(negedge clk);
    drive(v[4]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("rst_flight.mismatch", mismatch, 0);
    chk("rst_flight.in_ready", bus.in_ready, 1);
    chk_outs("rst_flight");
    repeat (3) @(negedge clk);
    chk("rst_after.mismatch", mismatch, 0);
    chk_outs("rst_after");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 Parameter CNT_W, default 16: width of pass/fail/index counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clr  input  1  synchronous clear of counters, sticky flags and HALT state.
REQ-005 in_valid  input  1  beat present: stimulus plus ALU response.
REQ-006 in_ready  output  1  checker accepts beat; a beat transfers when in_valid && in_ready.
REQ-007 A, B  input  32 each  operands applied to the ALU.
REQ-008 ALUop  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-009 Result  input  32  ALU result under test.
REQ-010 Overflow, CarryOut, Zero  input  1 each  ALU flags under test.
REQ-011 mismatch  output  1  one-cycle pulse per failing beat.
REQ-012 mismatch_mask  output  5  {illegal_op, result, overflow, carry, zero} bits of last failing beat.
REQ-013 pass_cnt, fail_cnt  output  CNT_W each  beats passed / failed.
REQ-014 first_fail_idx  output  CNT_W  beat index (0-based) of first failure.
REQ-015 err  output  1  sticky: any failure since reset/clr.

Function
REQ-016 Pipeline: S1 registers accepted beat; S2 computes expected values and compare mask; S3 updates counters/outputs; mismatch asserts exactly 2 cycles after the accepting edge.
REQ-017 Throughput one beat per cycle while in_ready=1; no bubbles required.
REQ-018 Expected Result: AND A&B; OR A|B; ADD A+B mod 2^32; SUB A-B mod 2^32; SLT 32'h1 if signed A<B else 32'h0.
REQ-019 Expected Overflow: ADD/SUB signed overflow (operands' signs per op vs. result sign); not compared for AND/OR/SLT.
REQ-020 Expected CarryOut: ADD carry out of bit 31; SUB 1 iff unsigned A<B (borrow); not compared for AND/OR/SLT.
REQ-021 Expected Zero: 1 iff expected Result==0; compared for all legal ops.
REQ-022 Opcodes 011,100,101 illegal: no field compare, mask=5'b10000, counted as fail.
REQ-023 Beat passes iff mask==0; pass_cnt or fail_cnt increments by exactly 1 per accepted beat.
REQ-024 Counters saturate at all-ones; no wrap; index counter also saturates.
REQ-025 On first failure since reset/clr: first_fail_idx captured, err set; later failures update mismatch_mask only.
REQ-026 State machine: IDLE (no beat seen) -> RUN on first accepted beat; RUN -> HALT per REQ-033; HALT -> IDLE on clr; any state -> IDLE on rst.
REQ-027 clr same cycle as accepted beat: clr wins; beat and in-flight S1/S2 beats discarded, not counted.
REQ-028 in_valid with in_ready=0: no transfer, inputs ignored; producer holds stimulus.

Reset
REQ-029 rst overrides clr and in_valid; flushes pipeline (in-flight beats dropped).
REQ-030 After rst: in_ready=1, mismatch=0, mismatch_mask=0, pass_cnt=0, fail_cnt=0, first_fail_idx=0, err=0, state IDLE.
REQ-031 Reset asserted mid-stream: outputs reach reset values on the next edge; no partial counter update.

Configuration
REQ-032 Macro ALU_CHK_STOP_ON_FAIL_EN selects halt-on-failure.
REQ-033 Defined: S3 failure moves RUN -> HALT; in_ready=0 from next cycle until clr/rst; beats already in S1/S2 still checked and counted.
REQ-034 Undefined: HALT unreachable; in_ready constant 1 out of reset; checking continues past failures.

Verification
REQ-035 ADD A=32'h7FFFFFFF B=32'h1, Result=32'h80000000 Overflow=1 CarryOut=0 Zero=0 -> pass_cnt=1, mismatch stays 0.
REQ-036 SUB A=32'h80000001 B=32'h7FFFFFF2, Result=32'h0000000F Overflow=0 -> mismatch pulse at cycle+2, mask=5'b00100, fail_cnt=1, first_fail_idx=0, err=1.
REQ-037 SLT A=32'h80000001 B=32'h1 Result=32'h1 Zero=0, then ALUop=3'b100 -> pass_cnt=1, fail_cnt=1, mask=5'b10000.
REQ-038 SUB A=B=32'hFFFFFFFF with Zero=0, ALU Result=0 -> mask=5'b00001; with STOP_ON_FAIL_EN in_ready=0 until clr, then IDLE and all counters 0.
REQ-039 Back-to-back 2^CNT_W+3 passing AND beats -> pass_cnt saturates at all-ones, fail_cnt=0.
REQ-040 rst asserted while 2 beats in flight -> no counter change, all outputs at reset values next cycle.
